// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a sign/half-select fix-up cycle before the result strobe.
module mdu_iter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] DataA_i,
  input  logic [XLEN-1:0] DataB_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o
);

  localparam int unsigned DW = 2 * XLEN;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [2:0]       op_q;
  logic [4:0]       rd_q;
  logic             a_neg_q, b_neg_q;
  logic [XLEN-1:0]  opnd_q;
  logic [DW-1:0]    acc_q;

  // Operand decode at acceptance
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div   = op_i[2];
    a_sgn    = is_div ? ~op_i[0] : (op_i[1:0] != 2'b11);
    b_sgn    = is_div ? ~op_i[0] : ~op_i[1];
    a_neg    = a_sgn & DataA_i[XLEN-1];
    b_neg    = b_sgn & DataB_i[XLEN-1];
    a_mag    = a_neg ? -DataA_i : DataA_i;
    b_mag    = b_neg ? -DataB_i : DataB_i;
    div_zero = is_div & (DataB_i == '0);
    div_ovf  = is_div & ~op_i[0] & (DataA_i == INT_MIN) & (DataB_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = op_i[1] ? DataA_i : '1;
    else          special_res = op_i[1] ? '0 : INT_MIN;
  end

  // One iteration of multiply (shift-add) and divide (restoring)
  logic [XLEN:0]   mul_sum;
  logic [DW-1:0]   mul_next;
  logic [XLEN:0]   div_sh, div_diff;
  logic            div_ge;
  logic [DW-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = acc_q[DW-1:XLEN-1];
    div_diff = div_sh - {1'b0, opnd_q};
    div_ge   = ~div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  end

  // Sign correction and half select
  logic [DW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo_fix  = (a_neg_q ^ b_neg_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = a_neg_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];
    if (op_q[2])              fix_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == '0) fix_res = prod_fix[XLEN-1:0];
    else                      fix_res = prod_fix[DW-1:XLEN];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    valid_o = 1'b0;
    accept  = start_i & ~kill_i & ((state_q == S_IDLE) | (state_q == S_DONE));
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = special ? S_DONE : S_CALC;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        busy_o  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        valid_o = ~kill_i;
        state_d = S_IDLE;
        if (accept) begin
          state_d = special ? S_DONE : S_CALC;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Datapath: latch on acceptance, iterate in CALC, commit in FIX
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q      <= '0;
      rd_q      <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_o  <= '0;
      rd_addr_o <= '0;
    end else if (accept) begin
      op_q    <= op_i;
      rd_q    <= rd_addr_i;
      a_neg_q <= a_neg;
      b_neg_q <= b_neg;
      opnd_q  <= is_div ? b_mag : a_mag;
      acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      if (special) begin
        result_o  <= special_res;
        rd_addr_o <= rd_addr_i;
      end
    end else if (!kill_i) begin
      if (state_q == S_CALC) begin
        acc_q <= op_q[2] ? div_next : mul_next;
      end else if (state_q == S_FIX) begin
        result_o  <= fix_res;
        rd_addr_o <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: results, latency, busy, kill, reset and back-to-back.
module tb_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic        kill_i;
  logic [2:0]  op_i;
  logic [31:0] DataA_i;
  logic [31:0] DataB_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .kill_i    (kill_i),
    .op_i      (op_i),
    .DataA_i   (DataA_i),
    .DataB_i   (DataB_i),
    .rd_addr_i (rd_addr_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .rd_addr_o (rd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op, scramble inputs after acceptance, wait (bounded) for valid_o.
  // Returns in the valid cycle; lat=1 means valid in the cycle after acceptance.
  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int exp_lat, input bit poke);
    int lat = 0;
    int bc  = 0;
    logic [31:0] res = '0;
    logic [4:0]  rda = '0;
    start_i = 1'b1; op_i = op; DataA_i = a; DataB_i = b; rd_addr_i = rd;
    tick();
    start_i = 1'b0; DataA_i = $urandom; DataB_i = $urandom;
    rd_addr_i = 5'($urandom); op_i = 3'($urandom_range(0, 7));
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      if (poke && k == 5) begin
        start_i = 1'b1; op_i = DIVU; DataB_i = '0; rd_addr_i = 5'd31;
      end
      if (poke && k == 6) start_i = 1'b0;
      if (busy_o) bc++;
      if (valid_o) begin
        lat = k; res = result_o; rda = rd_addr_o;
      end else begin
        tick();
      end
    end
    start_i = 1'b0;
    chk({tag, " result"}, res, exp);
    chk({tag, " rd"}, 32'(rda), 32'(rd));
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(bc), (exp_lat == 34) ? 32'd33 : 32'd0);
  endtask

  initial begin
    int nvalid;
    rst_n_i = 1'b0; start_i = 1'b0; kill_i = 1'b0; op_i = '0;
    DataA_i = '0; DataB_i = '0; rd_addr_i = '0;
    #1;
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset rd", 32'(rd_addr_o), 32'd0);
    tick(); tick();
    rst_n_i = 1'b1;
    tick();

    // Multiplies
    run("mul", MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 1'b0);
    tick();
    chk("hold valid", 32'(valid_o), 32'd0);
    chk("hold result", result_o, 32'hFFFF_FFEB);
    run("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, 1'b0);
    tick();
    run("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34, 1'b0);
    tick();
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 34, 1'b0);
    tick();

    // Divides
    run("div", DIV, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34, 1'b0);
    tick();
    run("rem", REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 34, 1'b0);
    tick();
    run("divu", DIVU, 32'd100, 32'd7, 5'd12, 32'd14, 34, 1'b0);
    tick();
    run("remu", REMU, 32'd100, 32'd7, 5'd8, 32'd2, 34, 1'b0);
    tick();

    // Kill at CALC cycle 10, then immediate restart
    start_i = 1'b1; op_i = MUL; DataA_i = 32'd9; DataB_i = 32'd9; rd_addr_i = 5'd9;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    kill_i = 1'b1;
    #1;
    chk("kill busy_before", 32'(busy_o), 32'd1);
    tick();
    kill_i = 1'b0;
    chk("kill busy_after", 32'(busy_o), 32'd0);
    chk("kill result_held", result_o, 32'd2);
    chk("kill rd_held", 32'(rd_addr_o), 32'd8);
    run("after_kill", MULHU, 32'h0001_0000, 32'h0003_0000, 5'd11, 32'd3, 34, 1'b0);
    tick();

    // Special divide cases
    run("divu_by0", DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1, 1'b0);
    tick();
    run("remu_by0", REMU, 32'd5, 32'd0, 5'd14, 32'd5, 1, 1'b0);
    tick();
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 1'b0);
    tick();
    run("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 1'b0);
    tick();
    run("rem_by0_neg", REM, 32'hFFFF_FFF9, 32'd0, 5'd17, 32'hFFFF_FFF9, 1, 1'b0);
    // Kill in the DONE cycle suppresses the strobe
    kill_i = 1'b1;
    #1;
    chk("kill_done valid", 32'(valid_o), 32'd0);
    tick();
    kill_i = 1'b0;
    chk("kill_done after", 32'(valid_o), 32'd0);

    // Kill together with start: nothing accepted
    start_i = 1'b1; kill_i = 1'b1; op_i = DIVU; DataA_i = 32'd1; DataB_i = 32'd0; rd_addr_i = 5'd20;
    tick();
    start_i = 1'b0; kill_i = 1'b0;
    chk("kill_start valid", 32'(valid_o), 32'd0);
    tick();
    chk("kill_start valid2", 32'(valid_o), 32'd0);
    chk("kill_start rd_held", 32'(rd_addr_o), 32'd17);

    // Reset mid-CALC
    start_i = 1'b1; op_i = MUL; DataA_i = 32'd3; DataB_i = 32'd3; rd_addr_i = 5'd21;
    tick();
    start_i = 1'b0;
    repeat (5) tick();
    rst_n_i = 1'b0;
    #1;
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst result", result_o, 32'd0);
    chk("rst rd", 32'(rd_addr_o), 32'd0);
    tick();
    rst_n_i = 1'b1;
    nvalid = 0;
    repeat (40) begin
      tick();
      if (valid_o) nvalid++;
    end
    chk("rst no_valid", 32'(nvalid), 32'd0);

    // Back-to-back: restart in the DONE cycle, with stray start pulses during CALC
    run("b2b mul", MUL, 32'd3, 32'd5, 5'd4, 32'd15, 34, 1'b1);
    run("b2b divu", DIVU, 32'd9, 32'd3, 5'd6, 32'd3, 34, 1'b1);
    tick();
    chk("b2b idle busy", 32'(busy_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- It is a peer consumer of the ALU operand-select outputs:
  - operand A is the selected DataA (register or PC path);
  - operand B is the selected DataB.
- It accepts one M-extension operation per start pulse and computes it over multiple cycles.
- It returns a one-cycle valid result tagged with the destination register.
- The hazard unit uses busy_o to stall IF/ID/EX while an operation is in flight.

Parameters:
- XLEN, 32, operand/result width (matches `RegBus`).
- CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request; accepted only in IDLE or DONE.
- kill_i  in  1  pipeline flush; aborts any in-flight operation.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DataA_i  in  XLEN  rs1 operand (after A select).
- DataB_i  in  XLEN  rs2 operand (after B select).
- rd_addr_i  in  5  destination tag.
- busy_o  out  1  high in CALC and FIX.
- valid_o  out  1  result strobe.
- result_o  out  XLEN  result, held until the next valid.
- rd_addr_o  out  5  tag of the result.

Behaviour:
- Reset (async, rst_n_i=0):
  - state=IDLE, counter=0.
  - busy_o=0, valid_o=0, result_o=0, rd_addr_o=0.
  - Any in-flight operation is discarded; no valid after release.
- Acceptance:
  - start_i=1 and kill_i=0 at a rising edge while in IDLE or DONE.
  - op_i, DataA_i, DataB_i and rd_addr_i are latched at that edge.
  - Operands may change freely afterwards.
  - start_i in CALC or FIX is ignored.
- States:
  - IDLE: waits for acceptance.
    - Special divide case -> DONE.
    - Otherwise -> CALC with counter=0.
  - CALC: one iteration per cycle, counter+1.
    - When counter reaches XLEN-1, the next edge goes to FIX.
    - Exactly XLEN cycles are spent in CALC.
  - FIX: sign correction and upper/lower half select; result_o and rd_addr_o are registered. Next edge -> DONE.
  - DONE: one cycle.
    - Acceptance -> CALC (or DONE again for a special case).
    - Otherwise -> IDLE.
- Latency:
  - Normal op accepted at edge T: valid_o is high for exactly the cycle following edge T+XLEN+1 (34 edges for XLEN=32).
  - Special case accepted at edge T: valid_o is high for the cycle following edge T.
- Outputs:
  - valid_o = (state==DONE) & ~kill_i.
  - busy_o = (state==CALC) | (state==FIX).
- Multiply:
  - Unsigned shift-add on operand magnitudes into a 2*XLEN accumulator.
  - Signedness: MUL/MULH treat A and B as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - The product is negated in FIX when the operand signs differ.
  - MUL returns the low XLEN bits; the other multiplies return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signedness: DIV/REM signed; DIVU/REMU unsigned.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Special divide cases, resolved without CALC:
  - B==0: quotient = all ones; remainder = A.
  - Signed overflow (A==0x80000000, B==0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Kill:
  - kill_i=1 at an edge in any state forces IDLE and suppresses the current valid_o.
  - kill_i together with start_i: kill wins and nothing is accepted.
  - result_o and rd_addr_o keep their last committed values.
- Back-to-back: acceptance in DONE gives a gapless restart; the valid cycle of op N coincides with the acceptance of op N+1.

Test Plan:
- MUL A=7, B=0xFFFFFFFD -> result 0xFFFFFFEB, valid exactly 34 cycles after start, busy high for 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All special cases valid 1 cycle after start, busy_o never set.
- Kill at CALC cycle 10 -> no valid, back to IDLE, result_o unchanged. A new start on the next cycle completes normally with the correct rd_addr_o. Assert rst_n_i mid-CALC -> all outputs 0 immediately, no valid after release.
- Back-to-back: start MUL 3*5 (rd=4), then re-start DIVU 9/3 (rd=6) in its DONE cycle -> valid 15/rd=4, then 34 cycles later valid 3/rd=6. start_i pulses during CALC are ignored.
